// File: rtl/pipelined_ctrl_unit.sv
// Pipelined MIPS control: ID decode into control bundles carried through EX/MEM/WB
// with per-stage valid bits, plus load-use stall and branch-taken flush generation.
module pipelined_ctrl_unit #(
    parameter int   ALUCTL_W  = 4,
    parameter logic HAZARD_EN = 1'b1
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [31:0]         Instruction,
    input  logic                IdValid,
    input  logic                Zero,
    output logic                ExALUSrc,
    output logic                ExRegDst,
    output logic [ALUCTL_W-1:0] ExALUControl,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                WbRegWrite,
    output logic                WbMemToReg,
    output logic                PCSrc,
    output logic                Jump,
    output logic                Stall,
    output logic                IllegalOp
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    logic [5:0] id_op;
    logic [5:0] id_funct;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       unused_fields;

    assign id_op         = Instruction[31:26];
    assign id_rs         = Instruction[25:21];
    assign id_rt         = Instruction[20:16];
    assign id_funct      = Instruction[5:0];
    assign unused_fields = ^Instruction[15:6];

    logic       id_alusrc, id_regdst, id_memread, id_memwrite;
    logic       id_regwrite, id_memtoreg, id_beq, id_bne, id_jump;
    logic       id_illegal, id_uses_rs, id_uses_rt;
    logic [3:0] id_aluctl;

    // ---- ID: decode ----
    always_comb begin
        id_alusrc   = 1'b0;
        id_regdst   = 1'b0;
        id_memread  = 1'b0;
        id_memwrite = 1'b0;
        id_regwrite = 1'b0;
        id_memtoreg = 1'b0;
        id_beq      = 1'b0;
        id_bne      = 1'b0;
        id_jump     = 1'b0;
        id_illegal  = 1'b0;
        id_uses_rs  = 1'b0;
        id_uses_rt  = 1'b0;
        id_aluctl   = ALU_AND;
        if (Instruction != 32'd0) begin
            case (id_op)
                OP_RTYPE: begin
                    id_regdst   = 1'b1;
                    id_regwrite = 1'b1;
                    id_uses_rs  = 1'b1;
                    id_uses_rt  = 1'b1;
                    case (id_funct)
                        6'b100000: id_aluctl = ALU_ADD;
                        6'b100010: id_aluctl = ALU_SUB;
                        6'b100100: id_aluctl = ALU_AND;
                        6'b100101: id_aluctl = ALU_OR;
                        6'b100110: id_aluctl = ALU_XOR;
                        6'b100111: id_aluctl = ALU_NOR;
                        6'b101010: id_aluctl = ALU_SLT;
                        6'b000000: id_aluctl = ALU_SLL;
                        6'b000010: id_aluctl = ALU_SRL;
                        default:   id_illegal = 1'b1;
                    endcase
                end
                OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                    id_alusrc   = 1'b1;
                    id_regwrite = 1'b1;
                    id_uses_rs  = 1'b1;
                    case (id_op)
                        OP_ANDI: id_aluctl = ALU_AND;
                        OP_ORI:  id_aluctl = ALU_OR;
                        OP_SLTI: id_aluctl = ALU_SLT;
                        default: id_aluctl = ALU_ADD;
                    endcase
                end
                OP_LW: begin
                    id_alusrc   = 1'b1;
                    id_memread  = 1'b1;
                    id_regwrite = 1'b1;
                    id_memtoreg = 1'b1;
                    id_uses_rs  = 1'b1;
                    id_aluctl   = ALU_ADD;
                end
                OP_SW: begin
                    id_alusrc   = 1'b1;
                    id_memwrite = 1'b1;
                    id_uses_rs  = 1'b1;
                    id_uses_rt  = 1'b1;
                    id_aluctl   = ALU_ADD;
                end
                OP_BEQ, OP_BNE: begin
                    id_beq     = (id_op == OP_BEQ);
                    id_bne     = (id_op == OP_BNE);
                    id_uses_rs = 1'b1;
                    id_uses_rt = 1'b1;
                    id_aluctl  = ALU_SUB;
                end
                OP_J:    id_jump    = 1'b1;
                default: id_illegal = 1'b1;
            endcase
            // An undecodable word must not leak partial controls downstream.
            if (id_illegal) begin
                id_regdst   = 1'b0;
                id_regwrite = 1'b0;
                id_uses_rs  = 1'b0;
                id_uses_rt  = 1'b0;
                id_aluctl   = ALU_AND;
            end
        end
    end

    logic       ex_vld_q, mem_vld_q, wb_vld_q, illegal_q;
    logic       ex_vld_d;
    logic       ex_alusrc_q, ex_regdst_q, ex_memread_q, ex_memwrite_q;
    logic       ex_regwrite_q, ex_memtoreg_q, ex_beq_q, ex_bne_q;
    logic [3:0] ex_aluctl_q;
    logic [4:0] ex_rt_q;
    logic       mem_memread_q, mem_memwrite_q, mem_regwrite_q, mem_memtoreg_q;
    logic       wb_regwrite_q, wb_memtoreg_q;
    logic       load_use;

    assign load_use = ex_vld_q & ex_memread_q & (ex_rt_q != 5'd0) &
                      ((id_uses_rs & (ex_rt_q == id_rs)) | (id_uses_rt & (ex_rt_q == id_rt)));
    assign Stall    = HAZARD_EN & IdValid & load_use;
    assign PCSrc    = ex_vld_q & ((ex_beq_q & Zero) | (ex_bne_q & ~Zero));
    assign Jump     = IdValid & id_jump;
    // Flush outranks stall; either one turns the EX load into a bubble.
    assign ex_vld_d = IdValid & ~PCSrc & ~Stall;

    // ---- valid bits and IllegalOp (reset) ----
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ex_vld_q  <= 1'b0;
            mem_vld_q <= 1'b0;
            wb_vld_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            ex_vld_q  <= ex_vld_d;
            mem_vld_q <= ex_vld_q;
            wb_vld_q  <= mem_vld_q;
            illegal_q <= IdValid & id_illegal;
        end
    end

    // ---- ID -> EX -> MEM -> WB control payload (qualified by valid bits) ----
    always_ff @(posedge Clk) begin
        ex_alusrc_q    <= id_alusrc;
        ex_regdst_q    <= id_regdst;
        ex_aluctl_q    <= id_aluctl;
        ex_memread_q   <= id_memread;
        ex_memwrite_q  <= id_memwrite;
        ex_regwrite_q  <= id_regwrite;
        ex_memtoreg_q  <= id_memtoreg;
        ex_beq_q       <= id_beq;
        ex_bne_q       <= id_bne;
        ex_rt_q        <= id_rt;
        mem_memread_q  <= ex_memread_q;
        mem_memwrite_q <= ex_memwrite_q;
        mem_regwrite_q <= ex_regwrite_q;
        mem_memtoreg_q <= ex_memtoreg_q;
        wb_regwrite_q  <= mem_regwrite_q;
        wb_memtoreg_q  <= mem_memtoreg_q;
    end

    assign ExALUSrc     = ex_vld_q & ex_alusrc_q;
    assign ExRegDst     = ex_vld_q & ex_regdst_q;
    assign ExALUControl = ex_vld_q ? ALUCTL_W'(ex_aluctl_q) : '0;
    assign MemRead      = mem_vld_q & mem_memread_q;
    assign MemWrite     = mem_vld_q & mem_memwrite_q;
    assign WbRegWrite   = wb_vld_q & wb_regwrite_q;
    assign WbMemToReg   = wb_vld_q & wb_memtoreg_q;
    assign IllegalOp    = illegal_q;

endmodule

// File: tb/tb_pipelined_ctrl_unit.sv
// Scoreboard bench: table-driven instruction reference model predicts per-cycle outputs
// of two instances (hazard detection on / off, 4- and 6-bit ALUControl).
module tb_pipelined_ctrl_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, idv, zero;
    logic [31:0] instr;

    logic       a0_alusrc, a0_regdst, a0_mr, a0_mw, a0_rw, a0_m2r, a0_pcs, a0_j, a0_stall, a0_ill;
    logic [3:0] a0_alu;
    logic       a1_alusrc, a1_regdst, a1_mr, a1_mw, a1_rw, a1_m2r, a1_pcs, a1_j, a1_stall, a1_ill;
    logic [5:0] a1_alu;

    pipelined_ctrl_unit #(.ALUCTL_W(4), .HAZARD_EN(1'b1)) dut0 (
        .Clk(clk), .Rst(rst), .Instruction(instr), .IdValid(idv), .Zero(zero),
        .ExALUSrc(a0_alusrc), .ExRegDst(a0_regdst), .ExALUControl(a0_alu),
        .MemRead(a0_mr), .MemWrite(a0_mw), .WbRegWrite(a0_rw), .WbMemToReg(a0_m2r),
        .PCSrc(a0_pcs), .Jump(a0_j), .Stall(a0_stall), .IllegalOp(a0_ill)
    );

    pipelined_ctrl_unit #(.ALUCTL_W(6), .HAZARD_EN(1'b0)) dut1 (
        .Clk(clk), .Rst(rst), .Instruction(instr), .IdValid(idv), .Zero(zero),
        .ExALUSrc(a1_alusrc), .ExRegDst(a1_regdst), .ExALUControl(a1_alu),
        .MemRead(a1_mr), .MemWrite(a1_mw), .WbRegWrite(a1_rw), .WbMemToReg(a1_m2r),
        .PCSrc(a1_pcs), .Jump(a1_j), .Stall(a1_stall), .IllegalOp(a1_ill)
    );

    // Instruction catalogue: what each mnemonic should produce.
    typedef struct packed {
        logic [5:0] op;
        logic [5:0] funct;
        logic       rtype, alusrc, regdst;
        logic [3:0] alu;
        logic       mr, mw, rw, m2r, beq, bne, j, ill, nop, urs, urt;
    } ent_t;

    typedef struct packed {
        logic       v, alusrc, regdst;
        logic [3:0] alu;
        logic       mr, mw, rw, m2r, beq, bne;
        logic [4:0] rt;
    } bnd_t;

    typedef struct packed {
        logic [7:0] ex;
        logic [1:0] mem;
        logic [1:0] wb;
        logic [3:0] comb;
    } exp_t;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5;
    localparam int K_J = 6, K_NOP = 7, K_ILLOP = 8, K_ILLF = 9;
    localparam int E_ADD = 0, E_SUB = 1, E_AND = 2, E_OR = 3, E_XOR = 4, E_NOR = 5, E_SLT = 6;
    localparam int E_SLL = 7, E_SRL = 8, E_ADDI = 9, E_ANDI = 10, E_ORI = 11, E_SLTI = 12;
    localparam int E_LW = 13, E_SW = 14, E_BEQ = 15, E_BNE = 16, E_J = 17, E_NOP = 18;
    localparam int E_ILLOP = 19, E_ILLF = 20, NENT = 21;
    localparam int HMAX = 4096;

    ent_t tbl [NENT];
    bnd_t hist [2][HMAX];
    logic prev_ill [2];
    exp_t q0[$], q1[$];
    int   cyc, mcyc;
    int   checks = 0;
    int   errors = 0;

    function automatic ent_t mk(input int k, input logic [5:0] op, input logic [5:0] fn,
                                input logic [3:0] alu);
        ent_t t = '0;
        t.op = op; t.funct = fn; t.alu = alu;
        case (k)
            K_R:     begin t.rtype = 1; t.regdst = 1; t.rw = 1; t.urs = 1; t.urt = 1; end
            K_I:     begin t.alusrc = 1; t.rw = 1; t.urs = 1; end
            K_LW:    begin t.alusrc = 1; t.mr = 1; t.rw = 1; t.m2r = 1; t.urs = 1; end
            K_SW:    begin t.alusrc = 1; t.mw = 1; t.urs = 1; t.urt = 1; end
            K_BEQ:   begin t.beq = 1; t.urs = 1; t.urt = 1; end
            K_BNE:   begin t.bne = 1; t.urs = 1; t.urt = 1; end
            K_J:     t.j = 1;
            K_NOP:   t.nop = 1;
            K_ILLOP: t.ill = 1;
            default: begin t.rtype = 1; t.ill = 1; end
        endcase
        return t;
    endfunction

    function automatic logic [31:0] build(input int e, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd);
        ent_t t = tbl[e];
        logic [31:0] w;
        if (t.nop)                w = 32'd0;
        else if (t.rtype)         w = {6'b000000, rs, rt, rd, 5'($urandom_range(0, 31)), t.funct};
        else if (t.j || t.ill)    w = {t.op, 26'($urandom)};
        else                      w = {t.op, rs, rt, 16'($urandom)};
        if (!t.nop && w == 32'd0) w[15:11] = 5'd1;
        return w;
    endfunction

    // One clock of stimulus: predict this cycle's outputs, then what EX holds next.
    task automatic step(input int e, input logic [31:0] w, input logic v, input logic z,
                        input logic r, output logic stalled);
        ent_t t = tbl[e];
        bnd_t ex, mem, wb, nb;
        logic pcs, stl;
        exp_t x;
        if (cyc >= HMAX - 2) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, HMAX - 2);
            $fatal(1, "bench cycle budget exhausted");
        end
        instr = w; idv = v; zero = z; rst = r;
        stalled = 1'b0;
        for (int d = 0; d < 2; d++) begin
            ex  = hist[d][cyc];
            mem = hist[d][cyc-1];
            wb  = hist[d][cyc-2];
            pcs = ex.v & ((ex.beq & z) | (ex.bne & ~z));
            stl = (d == 0) & v & ex.v & ex.mr & (ex.rt != 5'd0) &
                  ((t.urs & (ex.rt == w[25:21])) | (t.urt & (ex.rt == w[20:16])));
            x.ex   = {ex.alusrc, ex.regdst, 2'b00, ex.alu};
            x.mem  = {mem.mr, mem.mw};
            x.wb   = {wb.rw, wb.m2r};
            x.comb = {pcs, v & t.j, stl, prev_ill[d]};
            if (d == 0) q0.push_back(x); else q1.push_back(x);
            if (r) begin
                hist[d][cyc+1] = '0;
                hist[d][cyc]   = '0;
                hist[d][cyc-1] = '0;
                prev_ill[d]    = 1'b0;
            end else begin
                nb = '0;
                if (v && !pcs && !stl)
                    nb = {1'b1, t.alusrc, t.regdst, t.alu, t.mr, t.mw, t.rw, t.m2r,
                          t.beq, t.bne, w[20:16]};
                hist[d][cyc+1] = nb;
                prev_ill[d]    = v & t.ill;
            end
            if (d == 0) stalled = stl;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Upstream behaviour: the same word is re-presented while Stall is high.
    task automatic issue(input int e, input int rs, input int rt, input int rd,
                         input logic v, input logic z, input logic r);
        logic [31:0] w;
        logic s;
        w = build(e, 5'(rs), 5'(rt), 5'(rd));
        for (int n = 0; n < 4; n++) begin
            step(e, w, v, z, r, s);
            if (!s) break;
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, mcyc, act, exp);
        end
    endtask

    // Monitor: one expected output vector per instance per cycle.
    always @(negedge clk) begin
        exp_t x, a;
        mcyc++;
        if (q0.size() > 0) begin
            x = q0.pop_front();
            a = {a0_alusrc, a0_regdst, 2'b00, a0_alu, a0_mr, a0_mw, a0_rw, a0_m2r,
                 a0_pcs, a0_j, a0_stall, a0_ill};
            chk("dut0_ex",   a.ex, x.ex);
            chk("dut0_mem",  8'(a.mem), 8'(x.mem));
            chk("dut0_wb",   8'(a.wb), 8'(x.wb));
            chk("dut0_comb", 8'(a.comb), 8'(x.comb));
        end
        if (q1.size() > 0) begin
            x = q1.pop_front();
            a = {a1_alusrc, a1_regdst, a1_alu, a1_mr, a1_mw, a1_rw, a1_m2r,
                 a1_pcs, a1_j, a1_stall, a1_ill};
            chk("dut1_ex",   a.ex, x.ex);
            chk("dut1_mem",  8'(a.mem), 8'(x.mem));
            chk("dut1_wb",   8'(a.wb), 8'(x.wb));
            chk("dut1_comb", 8'(a.comb), 8'(x.comb));
        end
    end

    initial begin
        tbl[E_ADD]   = mk(K_R, 6'b000000, 6'b100000, 4'b0010);
        tbl[E_SUB]   = mk(K_R, 6'b000000, 6'b100010, 4'b0110);
        tbl[E_AND]   = mk(K_R, 6'b000000, 6'b100100, 4'b0000);
        tbl[E_OR]    = mk(K_R, 6'b000000, 6'b100101, 4'b0001);
        tbl[E_XOR]   = mk(K_R, 6'b000000, 6'b100110, 4'b1101);
        tbl[E_NOR]   = mk(K_R, 6'b000000, 6'b100111, 4'b1100);
        tbl[E_SLT]   = mk(K_R, 6'b000000, 6'b101010, 4'b0111);
        tbl[E_SLL]   = mk(K_R, 6'b000000, 6'b000000, 4'b1000);
        tbl[E_SRL]   = mk(K_R, 6'b000000, 6'b000010, 4'b1001);
        tbl[E_ADDI]  = mk(K_I, 6'b001000, 6'b000000, 4'b0010);
        tbl[E_ANDI]  = mk(K_I, 6'b001100, 6'b000000, 4'b0000);
        tbl[E_ORI]   = mk(K_I, 6'b001101, 6'b000000, 4'b0001);
        tbl[E_SLTI]  = mk(K_I, 6'b001010, 6'b000000, 4'b0111);
        tbl[E_LW]    = mk(K_LW, 6'b100011, 6'b000000, 4'b0010);
        tbl[E_SW]    = mk(K_SW, 6'b101011, 6'b000000, 4'b0010);
        tbl[E_BEQ]   = mk(K_BEQ, 6'b000100, 6'b000000, 4'b0110);
        tbl[E_BNE]   = mk(K_BNE, 6'b000101, 6'b000000, 4'b0110);
        tbl[E_J]     = mk(K_J, 6'b000010, 6'b000000, 4'b0000);
        tbl[E_NOP]   = mk(K_NOP, 6'b000000, 6'b000000, 4'b0000);
        tbl[E_ILLOP] = mk(K_ILLOP, 6'b111111, 6'b000000, 4'b0000);
        tbl[E_ILLF]  = mk(K_ILLF, 6'b000000, 6'b000001, 4'b0000);
        for (int d = 0; d < 2; d++) begin
            prev_ill[d] = 1'b0;
            for (int i = 0; i < HMAX; i++) hist[d][i] = '0;
        end
        mcyc = 0;
        cyc  = 2;

        // First reset edge establishes a known state before checking begins.
        rst = 1'b1; idv = 1'b1; zero = 1'b0; instr = build(E_LW, 5'd1, 5'd2, 5'd0);
        @(posedge clk);
        #1;

        issue(E_LW, 1, 2, 0, 1'b1, 1'b0, 1'b1);
        issue(E_LW, 1, 2, 0, 1'b1, 1'b0, 1'b1);
        issue(E_LW, 1, 2, 0, 1'b1, 1'b0, 1'b0);

        issue(E_ADD, 5, 6, 7, 1'b1, 1'b0, 1'b0);
        issue(E_LW,  1, 9, 0, 1'b1, 1'b0, 1'b0);
        issue(E_SW,  3, 4, 0, 1'b1, 1'b0, 1'b0);
        issue(E_SUB, 8, 10, 11, 1'b1, 1'b0, 1'b0);

        // Load-use via rs, via rt (SW), and an I-type whose rt must not stall.
        issue(E_LW,   1, 2, 0, 1'b1, 1'b0, 1'b0);
        issue(E_ADD,  2, 4, 3, 1'b1, 1'b0, 1'b0);
        issue(E_LW,   1, 5, 0, 1'b1, 1'b0, 1'b0);
        issue(E_SW,   6, 5, 0, 1'b1, 1'b0, 1'b0);
        issue(E_LW,   1, 7, 0, 1'b1, 1'b0, 1'b0);
        issue(E_ADDI, 1, 7, 0, 1'b1, 1'b0, 1'b0);
        issue(E_LW,   1, 0, 0, 1'b1, 1'b0, 1'b0);
        issue(E_ADD,  0, 0, 3, 1'b1, 1'b0, 1'b0);

        // Branches: BEQ taken, BNE with Zero=1 not taken, BNE taken.
        issue(E_BEQ, 1, 2, 0, 1'b1, 1'b0, 1'b0);
        issue(E_ADD, 3, 4, 5, 1'b1, 1'b1, 1'b0);
        issue(E_OR,  3, 4, 5, 1'b1, 1'b0, 1'b0);
        issue(E_BNE, 1, 2, 0, 1'b1, 1'b0, 1'b0);
        issue(E_ADD, 3, 4, 5, 1'b1, 1'b1, 1'b0);
        issue(E_BNE, 1, 2, 0, 1'b1, 1'b0, 1'b0);
        issue(E_AND, 3, 4, 5, 1'b1, 1'b0, 1'b0);

        // Load feeding a branch: stall, then the branch flushes its successor.
        issue(E_LW,  1, 3, 0, 1'b1, 1'b0, 1'b0);
        issue(E_BEQ, 3, 0, 0, 1'b1, 1'b0, 1'b0);
        issue(E_XOR, 6, 7, 8, 1'b1, 1'b1, 1'b0);
        issue(E_NOR, 6, 7, 8, 1'b1, 1'b0, 1'b0);

        // Illegal encodings, NOP, jump, and a bubble.
        issue(E_ILLOP, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        issue(E_NOP,   0, 0, 0, 1'b1, 1'b0, 1'b0);
        issue(E_ILLF,  1, 2, 3, 1'b1, 1'b0, 1'b0);
        issue(E_ILLOP, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        issue(E_J,     0, 0, 0, 1'b1, 1'b0, 1'b0);
        issue(E_LW,    1, 2, 0, 1'b0, 1'b0, 1'b0);
        issue(E_SRL,   1, 2, 3, 1'b1, 1'b0, 1'b0);

        // Reset with writes in flight.
        issue(E_LW,  1, 2, 0, 1'b1, 1'b0, 1'b0);
        issue(E_SW,  3, 4, 0, 1'b1, 1'b0, 1'b0);
        issue(E_ADD, 5, 6, 7, 1'b1, 1'b0, 1'b1);
        issue(E_SLL, 0, 1, 2, 1'b1, 1'b0, 1'b0);
        issue(E_NOP, 0, 0, 0, 1'b1, 1'b0, 1'b0);

        for (int k = 0; k < 1500; k++) begin
            issue($urandom_range(0, NENT - 1), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 31), ($urandom_range(0, 99) < 85), 1'($urandom),
                  ($urandom_range(0, 99) == 0));
        end
        issue(E_NOP, 0, 0, 0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d/%0d pending expected=0/0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipelined_ctrl_unit.md
# pipelined_ctrl_unit

Pipelined MIPS control unit that decodes the ID-stage instruction into control bundles and carries them through EX, MEM and WB stage registers with per-stage valid bits. It also generates the load-use stall and the branch-taken flush. The ALUControl encoding is widened, and decode covers I-type ALU ops, BNE and J. It sits beside the datapath pipeline registers and replaces the single-cycle controller/ALU-control pair.

## Interface
- ALUCTL_W, 4, ALUControl width; must be ≥4; bits above [3] are driven 0.
- HAZARD_EN, 1, 1 = load-use detection active; 0 = Stall tied 0.
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous, active-high reset.
- Instruction  in  32  ID-stage instruction; upstream holds it while Stall=1.
- IdValid  in  1  Instruction is a real instruction (0 = bubble).
- Zero  in  1  ALU zero flag for the EX-stage instruction.
- ExALUSrc, ExRegDst  out  1 each  EX controls.
- ExALUControl  out  ALUCTL_W  ALU operation.
- MemRead, MemWrite  out  1 each  MEM controls.
- WbRegWrite, WbMemToReg  out  1 each  WB controls.
- PCSrc  out  1  branch taken in EX (combinational).
- Jump  out  1  ID holds a valid J (combinational).
- Stall  out  1  load-use hazard; freeze PC/IF-ID (combinational).
- IllegalOp  out  1  registered one-cycle pulse on an undecodable valid instruction.

## Operation
- Decode (ID, combinational):
  - R-type (op 000000), by funct:
    - 100000 ADD→0010
    - 100010 SUB→0110
    - 100100 AND→0000
    - 100101 OR→0001
    - 100110 XOR→1101
    - 100111 NOR→1100
    - 101010 SLT→0111
    - 000000 SLL→1000
    - 000010 SRL→1001
  - R-type controls: RegDst=1, RegWrite=1.
  - I-type: ALUSrc=1, RegWrite=1, RegDst=0.
    - 001000 ADDI→0010
    - 001100 ANDI→0000
    - 001101 ORI→0001
    - 001010 SLTI→0111
  - 100011 LW: ALUSrc, MemRead, RegWrite, MemToReg; ADD.
  - 101011 SW: ALUSrc, MemWrite; ADD.
  - 000100 BEQ / 000101 BNE: SUB; no writes.
  - 000010 J: Jump=1; downstream bundle all-zero.
  - Instruction==0: NOP (all zero, not illegal).
- Illegal instruction: any other opcode, or an unknown R-type funct with a valid instruction. Decodes to an all-zero bundle; IllegalOp is set on the next edge.
- Stage registers: EX←ID, MEM←EX, WB←MEM every cycle; each carries a valid bit. An invalid stage drives all of its controls 0.
- Load-use: Stall=1 when HAZARD_EN, IdValid, EX valid & MemRead, ExRt≠0, and any of:
  - ExRt==IdRs, for R-type, I-type, LW, SW, BEQ, BNE;
  - ExRt==IdRt, for R-type, SW, BEQ, BNE.
- On a stall edge: EX loads a bubble; MEM and WB advance normally.
- Branch: PCSrc = ExValid & ((ExBeq & Zero) | (ExBne & ~Zero)).
  - On a PCSrc edge: EX loads a bubble (ID squashed).
  - The branch itself proceeds to MEM as a no-write bundle.
- Flush has priority over stall. Both set: EX gets a bubble; Stall output is still 1 that cycle.

## Timing
- Rst (sync): all valid bits 0, every registered output 0, IllegalOp 0. PCSrc/Stall therefore evaluate to 0 in the cycle after reset.
- Instruction decoded in cycle n:
  - EX outputs valid in n+1;
  - MemRead/MemWrite in n+2;
  - WbRegWrite/WbMemToReg in n+3.
- IllegalOp high exactly in cycle n+1.
- Stall and PCSrc are combinational in the same cycle as the causing state. A load-use stall lasts exactly one cycle, since the load leaves EX.
- Jump is combinational from Instruction and IdValid; it is not gated by Stall.
- Rst mid-stream: all in-flight bundles are discarded at that edge, with no partial write controls afterward.

## Test plan
- Reset: Rst=1 for 2 cycles with LW at ID → all outputs 0 throughout; deassert → LW's ExALUSrc=1, ExALUControl=0010 on the next cycle.
- Stream ADD, LW, SW, SUB → each bundle appears at EX/MEM/WB at n+1/n+2/n+3:
  - ADD: WbRegWrite=1;
  - LW: MemRead=1, WbMemToReg=1;
  - SW: MemWrite=1, no RegWrite.
- LW $2,0($1) followed by ADD $3,$2,$4 → Stall=1 for one cycle; EX bubble (all-zero); ADD reaches EX one cycle later. Repeat with HAZARD_EN=0 → no stall.
- BEQ in EX with Zero=1 → PCSrc=1; next-cycle EX all-zero. BNE with Zero=1 → PCSrc=0, no flush.
- Flush and stall together: LW then BEQ-taken arrangement forcing both → EX bubble; no duplicate instruction downstream.
- Illegal opcode 111111 with IdValid=1 → IllegalOp=1 for one cycle; no RegWrite/MemWrite ever asserted for it. Instruction=0 → IllegalOp stays 0.
